// File: rtl/weight_loader_pkg.sv
// Shared constants for the weight loader: fixed-point word width and FSM encoding.
package weight_loader_pkg;

  localparam int unsigned n = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StLoad = ST_LOAD,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/weight_loader_onehot_dec.sv
// Maps a node index to the reversed one-hot write-enable pattern (index 0 -> MSB).
module weight_loader_onehot_dec #(
  parameter int unsigned ND = 8,
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] idx_i,
  output logic [ND-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned k = 0; k < ND; k++) begin
      if (idx_i == CW'(k)) onehot_o[ND-1-k] = 1'b1;
    end
  end

endmodule

// File: rtl/weight_loader.sv
// Streams weight words into per-node shift registers via a shared bus and one-hot strobe.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned N   = n,
  parameter int unsigned ND  = 8,
  parameter int unsigned WPN = 4,
  parameter int unsigned CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [N-1:0]  bus,
  output logic [ND-1:0] we,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] node_idx
);

  localparam logic [CW-1:0] NodeLast = CW'(ND - 1);
  localparam logic [CW-1:0] WordLast = CW'(WPN - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] node_idx_q, node_idx_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [N-1:0]  bus_q, bus_d;
  logic [ND-1:0] we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [ND-1:0] dec_we;
  logic          xfer;

  weight_loader_onehot_dec #(
    .ND (ND),
    .CW (CW)
  ) u_dec (
    .idx_i    (node_idx_q),
    .onehot_o (dec_we)
  );

  // Abort gates ready so a word offered alongside abort is never consumed.
  assign s_ready = (state_q == StLoad) && !abort;
  assign xfer    = s_valid && s_ready;

  always_comb begin
    state_d    = state_q;
    node_idx_d = node_idx_q;
    wcnt_d     = wcnt_q;
    bus_d      = bus_q;
    we_d       = '0;
    if (abort) begin
      state_d    = StIdle;
      node_idx_d = '0;
      wcnt_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StLoad;
            node_idx_d = '0;
            wcnt_d     = '0;
          end
        end
        StLoad: begin
          if (xfer) begin
            bus_d = s_data;
            we_d  = dec_we;
            if (wcnt_q == WordLast) begin
              wcnt_d     = '0;
              node_idx_d = node_idx_q + CW'(1);
              if (node_idx_q == NodeLast) state_d = StDone;
            end else begin
              wcnt_d = wcnt_q + CW'(1);
            end
          end
        end
        StDone: begin
          state_d    = StIdle;
          node_idx_d = '0;
          wcnt_d     = '0;
        end
        default: begin
          state_d    = StIdle;
          node_idx_d = '0;
          wcnt_d     = '0;
        end
      endcase
    end
    busy_d = (state_d == StLoad);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      node_idx_q <= '0;
      wcnt_q     <= '0;
      bus_q      <= '0;
      we_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      node_idx_q <= node_idx_d;
      wcnt_q     <= wcnt_d;
      bus_q      <= bus_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus      = bus_q;
  assign we       = we_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign node_idx = node_idx_q;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench: directed scenarios plus random traffic against a stream-level model.
module tb_weight_loader;

  localparam int A_ND  = 3;
  localparam int A_WPN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready, busy, done;
  logic [15:0] bus;
  logic [2:0]  we;
  logic [7:0]  node_idx;

  logic        b_start = 1'b0, b_abort = 1'b0, b_valid = 1'b0;
  logic [15:0] b_data = '0;
  logic        b_s_ready, b_busy, b_done;
  logic [15:0] b_bus;
  logic [0:0]  b_we;
  logic [7:0]  b_node_idx;

  int n_cmp = 0;
  int n_err = 0;
  int n_strobe = 0;

  // Stream-level model: phase 0 idle, 1 loading, 2 done; m_cnt = words accepted this load.
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [15:0] m_bus = '0;

  weight_loader #(.N(16), .ND(A_ND), .WPN(A_WPN), .CW(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .bus(bus), .we(we), .busy(busy), .done(done), .node_idx(node_idx)
  );

  weight_loader #(.N(16), .ND(1), .WPN(1), .CW(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .s_data(b_data),
    .s_valid(b_valid), .s_ready(b_s_ready), .bus(b_bus), .we(b_we), .busy(b_busy),
    .done(b_done), .node_idx(b_node_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic st, input logic ab, input logic v, input logic [15:0] d);
    logic       acc;
    logic [2:0] exp_we;
    start = st; abort = ab; s_valid = v; s_data = d;
    #1;
    chk("s_ready", 32'(s_ready), 32'(m_phase == 1 && !ab));
    acc    = (m_phase == 1) && !ab && v;
    exp_we = acc ? 3'(1 << (A_ND - 1 - m_cnt / A_WPN)) : 3'b0;
    if (ab) begin
      m_phase = 0; m_cnt = 0;
    end else begin
      case (m_phase)
        0: if (st) begin m_phase = 1; m_cnt = 0; end
        1: if (acc) begin
             m_cnt++;
             if (m_cnt == A_ND * A_WPN) m_phase = 2;
           end
        default: begin m_phase = 0; m_cnt = 0; end
      endcase
    end
    if (acc) m_bus = d;
    @(posedge clk); #1;
    if (we !== 3'b0) n_strobe++;
    chk("we", 32'(we), 32'(exp_we));
    chk("bus", 32'(bus), 32'(m_bus));
    chk("busy", 32'(busy), 32'(m_phase == 1));
    chk("done", 32'(done), 32'(m_phase == 2));
    if (m_phase == 1) chk("node_idx", 32'(node_idx), 32'(m_cnt / A_WPN));
    else if (m_phase == 0) chk("node_idx_idle", 32'(node_idx), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_bus", 32'(bus), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_node", 32'(node_idx), 32'd0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back load of words 1..6.
    n_strobe = 0;
    step_a(1, 0, 0, 16'h0);
    for (int i = 1; i <= 6; i++) step_a(0, 0, 1, 16'(i));
    step_a(0, 0, 0, 16'h0);
    chk("strobes_b2b", 32'(n_strobe), 32'd6);

    // Gapped stream: valid 1,0,0,1,0,0,...
    n_strobe = 0;
    step_a(1, 0, 0, 16'h0);
    for (int c = 0; c < 40 && m_phase == 1; c++) step_a(0, 0, (c % 3) == 0, 16'($urandom));
    step_a(0, 0, 0, 16'h0);
    chk("strobes_gap", 32'(n_strobe), 32'd6);

    // Abort after three accepts, then a fresh full load.
    step_a(1, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) step_a(0, 0, 1, 16'($urandom));
    step_a(0, 1, 1, 16'hdead);
    step_a(0, 0, 1, 16'hbeef);
    step_a(1, 1, 0, 16'h0);
    step_a(0, 0, 0, 16'h0);
    n_strobe = 0;
    step_a(1, 0, 0, 16'h0);
    for (int i = 0; i < 6; i++) step_a(0, 0, 1, 16'($urandom));
    step_a(0, 0, 0, 16'h0);
    chk("strobes_after_abort", 32'(n_strobe), 32'd6);

    // Asynchronous reset at node_idx=1, wcnt=1.
    step_a(1, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) step_a(0, 0, 1, 16'($urandom));
    rst = 1'b0;
    #1;
    chk("arst_bus", 32'(bus), 32'd0);
    chk("arst_we", 32'(we), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_node", 32'(node_idx), 32'd0);
    #2 rst = 1'b1;
    m_phase = 0; m_cnt = 0; m_bus = '0;
    for (int i = 0; i < 3; i++) step_a(0, 0, 1, 16'($urandom));

    // Start during LOAD is ignored.
    n_strobe = 0;
    step_a(1, 0, 0, 16'h0);
    for (int i = 0; i < 2; i++) step_a(0, 0, 1, 16'($urandom));
    step_a(1, 0, 1, 16'($urandom));
    for (int i = 0; i < 3; i++) step_a(0, 0, 1, 16'($urandom));
    step_a(0, 0, 0, 16'h0);
    chk("strobes_restart", 32'(n_strobe), 32'd6);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step_a(($urandom % 6) == 0, ($urandom % 25) == 0, $urandom % 2, 16'($urandom));

    // Single-node, single-word configuration with a negative word.
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0; b_valid = 1'b1; b_data = 16'h8000;
    #1;
    chk("b_ready_load", 32'(b_s_ready), 32'd1);
    @(posedge clk); #1;
    b_valid = 1'b0;
    chk("b_we", 32'(b_we), 32'd1);
    chk("b_bus", 32'(b_bus), 32'h8000);
    chk("b_done", 32'(b_done), 32'd1);
    chk("b_ready_done", 32'(b_s_ready), 32'd0);
    chk("b_busy_done", 32'(b_busy), 32'd0);
    @(posedge clk); #1;
    chk("b_done_after", 32'(b_done), 32'd0);
    chk("b_we_after", 32'(b_we), 32'd0);
    chk("b_ready_idle", 32'(b_s_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Weight-load controller that drives the network's per-node weight shift registers.
- Accepts a serial stream of fixed-point weight words over a valid/ready handshake.
- Replays each word onto the shared `bus`, with a one-hot `we` strobe selecting the target node.
- Sits between the host/stream source and the network top level; it produces the `we`/`bus` pair the network consumes.

Parameters:
- N, 16: word width in bits; equals the codebase fixed-point width `n`.
- ND, 8: total node count; width of `we`.
- WPN, 4: words shifted into each node (inputs plus bias), ≥1.
- CW, 8: counter width; must satisfy 2^CW > max(ND, WPN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a full load, sampled only in IDLE.
- abort  in  1  synchronous abort, any state.
- s_data  in  N  incoming weight word, signed.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts a word this cycle.
- bus  out  N  word presented to node shift registers.
- we  out  ND  one-hot shift enable; bit ND-1 is the first node loaded.
- busy  out  1  high in LOAD.
- done  out  1  one-cycle pulse when the last word has been strobed.
- node_idx  out  CW  node currently being filled (0 = first node, i.e. `we[ND-1]`).

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE.
  - bus=0, we=0, s_ready=0, busy=0, done=0, node_idx=0.
  - Internal word counter wcnt=0.
- IDLE:
  - s_ready=0, we=0.
  - start=1 → LOAD; node_idx=0, wcnt=0.
- LOAD:
  - s_ready=1 combinationally while in LOAD and abort=0; busy=1.
  - A transfer occurs on a cycle with s_valid && s_ready.
  - On a transfer, the next cycle presents `bus <= s_data` and `we <= 1 << (ND-1-node_idx)`. All outputs are registered, so latency is 1 cycle.
  - `we` is zero on every cycle without a preceding transfer. Each transfer produces exactly one 1-cycle strobe on exactly one bit.
  - `bus` holds its last value when there is no transfer.
  - Counters advance on each transfer:
    - wcnt increments.
    - When wcnt==WPN-1, wcnt wraps to 0 and node_idx increments.
  - Transfer with node_idx==ND-1 and wcnt==WPN-1 → DONE. This last strobe appears in the same cycle DONE is entered.
- DONE:
  - done=1 for one cycle; s_ready=0; busy=0.
  - Next cycle → IDLE; node_idx and wcnt cleared.
- Gaps: s_valid low for any number of cycles stalls the load with no strobes and no counter change.
- start in LOAD or DONE is ignored.
- abort=1:
  - Next state is IDLE from any state.
  - we=0 next cycle; counters cleared; no done pulse.
  - A word presented with abort high is not accepted (s_ready=0).
  - abort and start together in IDLE: abort wins and the block stays IDLE.
- Reset asserted mid-LOAD: outputs clear immediately; a partial load is not resumed.
- Arithmetic: counters are unsigned CW bits. No sign handling; `bus` is a pass-through of the signed N-bit word.
- Total strobes per completed load = ND*WPN. Node k (0-based load order) receives words k*WPN .. k*WPN+WPN-1 of the stream, in stream order.

Decomposition:
- Shared package/header (extends the fixed-point header):
  - word width constant `n`.
  - state encoding constants ST_IDLE=2'd0, ST_LOAD=2'd1, ST_DONE=2'd2.
- One natural sub-module: `onehot_dec` (parameters ND, CW). Maps node_idx to the reversed one-hot `we` pattern; combinational, registered in the parent.

Test Plan:
- ND=3, WPN=2; start, then 6 back-to-back words 0x0001..0x0006 with s_valid=1.
  - we sequence 100,100,010,010,001,001 on the 6 cycles after each accept.
  - bus values 1..6 in order.
  - done high exactly one cycle, coincident with the final strobe+1 cycle state change.
- Same config with s_valid toggled 1,0,0,1,…: we=0 on every gap cycle, node_idx changes only after the 2nd accepted word, total of 6 strobes.
- abort asserted after 3 accepts: we=0 next cycle, busy=0, no done; a fresh start reloads from node_idx=0 with the first strobe on we=100.
- rst pulled low while node_idx=1, wcnt=1: bus=0, we=0, busy=0 in the same cycle (asynchronous); after release the block stays IDLE until start.
- start pulsed during LOAD after 2 accepts: no restart; counters continue and a total of 6 strobes complete.
- ND=1, WPN=1, single word 0x8000: one strobe we=1 with bus=0x8000 (sign preserved); done pulses; s_ready drops to 0 from the DONE cycle onward.
